// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control sequencer: state
// encoding, opcode/funct constants, ALU control codes, mux select codes
// and the per-state control word used by mc_control_fsm.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_NONE = 3'b000;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    // Control word for a state; anything not set here stays 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PCSRC_ALU;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = SRCB_IMM_SH;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWRITE: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            EXECUTE:  c.alu_src_a = 1'b1;
            ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.pc_src     = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_src     = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
// Bundle between the multicycle controller and the datapath.
//   master : controller side (drives selects/enables, sees IR fields and flags)
//   slave  : datapath side
// Inputs to the controller: opcode, funct, zero, mem_ready.
// Outputs from the controller: pc_en, iord, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
//   illegal_op, instr_done.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic       instr_done;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
               illegal_op, instr_done
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
               illegal_op, instr_done
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder
// Combinational ALU operation select for a given controller state.
//   state       in  state the ALU op is needed for
//   funct       in  IR[5:0], consulted only for EXECUTE
//   alu_control out 3-bit ALU operation code
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_NONE;
        case (state)
            FETCH, DECODE, MEMADR, ADDIEX: alu_control = ALU_ADD;
            BRANCH:                        alu_control = ALU_SUB;
            EXECUTE: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Moore sequencer for the multicycle MIPS datapath. Walks each instruction
// through fetch/decode/execute/memory/write-back and drives every datapath
// select and write enable from registered state-decoded outputs.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  master modport of mc_control_fsm_if (IR fields, flags, controls)
// Build option: MC_CTRL_MEM_WAIT_EN makes FETCH, MEMREAD and MEMWRITE hold
// until mem_ready; otherwise mem_ready is ignored.
//
// state    | meaning
// FETCH    | read instruction at PC into IR, PC <= PC + 4
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEMADR   | ALU computes rs + imm for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | MDR -> rt
// MEMWRITE | write rt to memory at ALUOut
// EXECUTE  | R-type ALU operation rs op rt
// ALUWB    | ALUOut -> rd
// BRANCH   | compare rs - rt, PC <= ALUOut if zero
// ADDIEX   | ALU computes rs + imm
// ADDIWB   | ALUOut -> rt
// JUMP     | PC <= jump target
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mc_control_fsm_if.master   bus
);

    state_t     state;
    state_t     state_next;
    state_t     target;
    logic       active;
    ctrl_t      ctrl_q;
    logic [2:0] alu_q;
    logic [2:0] alu_next;
    logic       mem_done;
    logic       mem_gate;
    logic       illegal_dec;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (mem_done) state_next = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_done) state_next = MEMWB;
            MEMWRITE: if (mem_done) state_next = FETCH;
            EXECUTE:  state_next = ALUWB;
            ADDIEX:   state_next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // The first edge after reset release only loads the FETCH output word,
    // so the first real FETCH cycle follows that edge.
    assign target = active ? state_next : state;

    mc_alu_decoder u_alu_decoder (
        .state       (target),
        .funct       (bus.funct),
        .alu_control (alu_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            active <= 1'b0;
            ctrl_q <= '0;
            alu_q  <= ALU_NONE;
        end else begin
            active <= 1'b1;
            state  <= target;
            ctrl_q <= state_ctrl(target);
            alu_q  <= alu_next;
        end
    end

    // Memory-facing strobes and completion only count in the mem_ready cycle
    // of a waiting state; mem_write itself stays high across the hold.
    assign mem_gate    = ((state == FETCH) || (state == MEMWRITE)) ? mem_done : 1'b1;
    assign illegal_dec = (state == DECODE) && !opcode_legal(bus.opcode);

    assign bus.pc_en       = (ctrl_q.pc_write & mem_gate) | (ctrl_q.branch & bus.zero);
    assign bus.iord        = ctrl_q.iord;
    assign bus.mem_write   = ctrl_q.mem_write;
    assign bus.ir_write    = ctrl_q.ir_write & mem_gate;
    assign bus.reg_dst     = ctrl_q.reg_dst;
    assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
    assign bus.reg_write   = ctrl_q.reg_write;
    assign bus.alu_src_a   = ctrl_q.alu_src_a;
    assign bus.alu_src_b   = ctrl_q.alu_src_b;
    assign bus.pc_src      = ctrl_q.pc_src;
    assign bus.alu_control = alu_q;
    assign bus.illegal_op  = illegal_dec;
    assign bus.instr_done  = (ctrl_q.instr_done & mem_gate) | illegal_dec;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencer for the MIPS datapath: a Moore state machine that walks each instruction through fetch, decode, execute, memory and write-back cycles over a single shared ALU and unified memory. It sits beside the register file, ALU, IR and PC registers and drives every mux select and write enable. It replaces single-cycle decoding when the datapath is built multicycle.

## Interface
- No parameters; opcode/funct/state encodings live in the package.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory access complete (used only with wait states compiled in)
- pc_en  out  1  PC load = pc_write | (branch & zero)
- iord  out  1  0: address = PC; 1: address = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  1: rd, 0: rt
- mem_to_reg  out  1  1: MDR, 0: ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0: PC, 1: rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  high during DECODE of an unsupported opcode
- instr_done  out  1  high in the final cycle of every instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_write=1 -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXECUTE; beq (000100) -> BRANCH; addi (001000) -> ADDIEX; j (000010) -> JUMP; other -> FETCH with illegal_op=1 and instr_done=1.
- MEMADR: alu_src_a=1, alu_src_b=10, add -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: iord=1 -> MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWRITE: iord=1, mem_write=1 -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct -> ALUWB. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- Funct decode in EXECUTE: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add (010).
- All outputs are decoded from the state register only, except pc_en (combinational in zero). Unlisted outputs are 0 in each state; unlisted selects hold 0.

## Timing
- Reset: state=FETCH; all strobes 0 while rst low; first FETCH cycle follows the first rising edge after release.
- Latency without waits: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; illegal 2.
- instr_done is asserted in MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH, JUMP and illegal DECODE.
- Reset asserted mid-instruction: immediate return to FETCH, all strobes drop asynchronously; no partial write may complete.

## Configuration
- MC_CTRL_MEM_WAIT_EN defined: FETCH, MEMREAD and MEMWRITE hold until mem_ready=1; in FETCH, ir_write and pc_write are asserted only in the mem_ready cycle; mem_write stays high throughout the MEMWRITE hold; instr_done in MEMWRITE only when mem_ready=1.
- Undefined: mem_ready is ignored; every memory state lasts exactly one cycle.

## Structure
- Package mc_ctrl_pkg: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, alu_control codes, alu_src_b/pc_src select codes.
- One sub-module: mc_alu_decoder (combinational funct/state -> alu_control), instantiated once.

## Test plan
- Reset release with opcode=100011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5 with mem_to_reg=1, reg_dst=0.
- R-type funct=101010 -> alu_control=111 in EXECUTE, reg_write with reg_dst=1 in cycle 4, instr_done only then.
- beq with zero=1 -> pc_en=1, pc_src=01 in cycle 3; repeat with zero=0 -> pc_en=0.
- opcode=111111 -> illegal_op=1 for one cycle, FETCH next; no reg_write or mem_write asserted.
- With MC_CTRL_MEM_WAIT_EN, sw with mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 cycles, total 7 cycles.
- rst pulsed low during MEMWRITE -> mem_write drops without a clock edge; FETCH after release.
